// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares one GCD engine among four requesters.
// Zero operands bypass the engine; a stuck engine is aborted after TIMEOUT wait cycles.
module gcd_arbiter #(
  parameter int unsigned TIMEOUT = 511
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [3:0]  ack,
  output logic [7:0]  result,
  output logic        err,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        eng_start,
  output logic [7:0]  eng_a,
  output logic [7:0]  eng_b,
  input  logic        eng_done,
  input  logic [7:0]  eng_gcd
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned IW    = 2;
  localparam int unsigned CW    = 10;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [DW-1:0] result_q, result_d;
  logic          err_q, err_d;
  logic [3:0]    ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          start_q, start_d;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] scan_idx;
  logic [DW-1:0] win_a, win_b;
  logic [CW-1:0] cnt_inc;

  // First asserted request scanning upward from the round-robin pointer
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 0; k < int'(N_REQ); k++) begin
      scan_idx = ptr_q + IW'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
    win_a = a_in[{win_idx, 3'b000} +: DW];
    win_b = b_in[{win_idx, 3'b000} +: DW];
  end

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    gid_d    = gid_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gid_d = win_idx;
          opa_d = win_a;
          opb_d = win_b;
          err_d = 1'b0;
          if (win_a == '0 || win_b == '0) begin
            result_d = win_a | win_b;
            state_d  = S_RESP;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // Engine completion takes priority over a coincident timeout
        if (eng_done) begin
          result_d = eng_gcd;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        ptr_d   = gid_q + IW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ack_d   = (state_d == S_RESP) ? (4'b0001 << gid_d) : 4'b0000;
    busy_d  = (state_d != S_IDLE);
    start_d = (state_d == S_LAUNCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      gid_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      gid_q    <= gid_d;
      result_q <= result_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
    end
  end

  assign ack       = ack_q;
  assign result    = result_q;
  assign err       = err_q;
  assign grant_id  = gid_q;
  assign busy      = busy_q;
  assign eng_start = start_q;
  assign eng_a     = opa_q;
  assign eng_b     = opb_q;

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 511, max WAIT cycles before abort; range 1..1023.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req  in  4  per-requester request level; bit i held high until ack[i].
REQ-005 a_in  in  32  operand a, requester i at bits [8i+7:8i]; stable while req[i] high.
REQ-006 b_in  in  32  operand b, same packing as a_in.
REQ-007 ack  out  4  one-cycle completion pulse to served requester.
REQ-008 result  out  8  GCD value; valid only while any ack bit high.
REQ-009 err  out  1  high with ack when transaction timed out.
REQ-010 grant_id  out  2  index of requester currently owning the engine.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 eng_start  out  1  one-cycle start strobe to shared GCD engine.
REQ-013 eng_a, eng_b  out  8 each  operands to engine, held constant from LAUNCH through WAIT.
REQ-014 eng_done  in  1  engine completion pulse.
REQ-015 eng_gcd  in  8  engine result, valid with eng_done.

Function
REQ-016 All outputs SHALL be registered (Moore, decoded from state and latched registers).
REQ-017 States SHALL be IDLE, LAUNCH, WAIT, RESP.
REQ-018 IDLE: if any req bit set, winner SHALL be first set bit scanning ptr, ptr+1, ... mod 4; winner's operands and index SHALL be latched at that edge.
REQ-019 IDLE with winner where a==0 or b==0: next state RESP, result = a|b (gcd(0,0)=0), no eng_start issued.
REQ-020 IDLE with winner, both operands nonzero: next state LAUNCH.
REQ-021 LAUNCH: eng_start=1 for exactly this cycle; next state WAIT; wait counter cleared.
REQ-022 WAIT: counter increments each cycle; eng_done=1 SHALL capture eng_gcd into result, err=0, next RESP.
REQ-023 WAIT: counter reaching TIMEOUT with eng_done=0 SHALL set result=0, err=1, next RESP; eng_done in that same cycle wins (normal completion).
REQ-024 RESP: ack[grant_id]=1 only, result and err valid, for exactly one cycle; ptr <= grant_id+1 mod 4; next IDLE.
REQ-025 Requester SHALL drop req at the edge ending its ack cycle; a req bit still high in the following IDLE cycle is a new request.
REQ-026 eng_done outside WAIT SHALL be ignored; req changes outside IDLE SHALL be ignored.
REQ-027 Latency: bypass ack 1 cycle after sampling edge; engine path ack 1 cycle after eng_done is sampled.
REQ-028 At most one transaction in flight; no back-to-back without one IDLE cycle.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE, ptr=0, counter=0, latched operands=0, all outputs 0.
REQ-030 Reset mid-transaction SHALL drop it without ack; a late eng_done after reset SHALL be ignored.

Verification
REQ-031 req[0], a=78, b=24; engine model done after 10 cycles returning 6 -> one eng_start with eng_a=78, eng_b=24; ack=0001, result=6, err=0.
REQ-032 After reset, req=1111 with (22,77),(89,23),(255,25),(236,136) held until ack -> acks in order 0,1,2,3; results 11,1,5,4; one IDLE cycle between each.
REQ-033 Serve requester 2, then req[1] and req[3] raised together -> ack[3] before ack[1] (ptr=3, wrap).
REQ-034 req[2], a=0, b=120 -> no eng_start, ack=0100, result=120, 1 cycle after sampling; a=0, b=0 -> result=0.
REQ-035 TIMEOUT=16, engine never completes -> ack with result=0, err=1 after 16 WAIT cycles; ptr advances; next request serviced normally.
REQ-036 rst pulsed during WAIT for requester 1, engine done 3 cycles later -> no ack, busy=0; subsequent req[0] served first (ptr=0).
